// File: rtl/fork2_reg.sv
// fork2_reg -- registered two-way stream fork.
//
// One input stream is copied onto two output branches through a single
// data register. Each accepted word is held until both branches have taken
// it. The branches may take the word on the same cycle or on different cycles.
// A new word can be loaded on the same cycle that the last pending branch
// takes the held word, so the fork sustains one word per cycle when both
// branches keep up.
//
// Handshake: a word moves on a stream only in a cycle where req=1 and ack=1.
// A req, once raised, stays high and its dat stays unchanged until ack is
// seen. Output reqs come from registered state only. t_0_ack depends on
// state and the branch acks, never on t_0_req.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   t_0_dat    incoming word
//   t_0_req    incoming word valid
//   t_0_ack    incoming word accepted
//   i_0_dat    held word, branch 0
//   i_0_req    branch 0 word valid
//   i_0_ack    branch 0 word taken
//   i_1_dat    held word, branch 1
//   i_1_req    branch 1 word valid
//   i_1_ack    branch 1 word taken
//   state_dbg  current state (0=EMPTY, 1=BOTH, 2=ONLY0, 3=ONLY1)
module fork2_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t_0_dat,
  input  logic             t_0_req,
  output logic             t_0_ack,
  output logic [WIDTH-1:0] i_0_dat,
  output logic             i_0_req,
  input  logic             i_0_ack,
  output logic [WIDTH-1:0] i_1_dat,
  output logic             i_1_req,
  input  logic             i_1_ack,
  output logic [1:0]       state_dbg
);

  // ONLYn means that only branch n still has to take the held word.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BOTH  = 2'd1,
    ONLY0 = 2'd2,
    ONLY1 = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] data_q;
  logic             free;   // register is empty, or is emptied this cycle
  logic             load;

  always_comb begin
    free    = 1'b0;
    state_d = state_q;
    case (state_q)
      EMPTY: free = 1'b1;
      BOTH: begin
        free = i_0_ack & i_1_ack;
        if (i_0_ack && !i_1_ack) state_d = ONLY1;
        else if (i_1_ack && !i_0_ack) state_d = ONLY0;
      end
      ONLY0: free = i_0_ack;   // i_1_ack is ignored here
      ONLY1: free = i_1_ack;   // i_0_ack is ignored here
      default: free = 1'b1;
    endcase
    // The last pending branch has taken the word, so a new word can be
    // loaded in the same cycle.
    if (free) state_d = t_0_req ? BOTH : EMPTY;
  end

  assign load = free & t_0_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) data_q <= t_0_dat;
    end
  end

  assign t_0_ack   = free;
  assign i_0_req   = (state_q == BOTH) || (state_q == ONLY0);
  assign i_1_req   = (state_q == BOTH) || (state_q == ONLY1);
  assign i_0_dat   = data_q;
  assign i_1_dat   = data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fork2_reg.sv
// tb_fork2_reg -- bench for fork2_reg. The reference model keeps one queue
// per branch holding the words that are still owed to that branch.
module tb_fork2_reg;
  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] t_0_dat;
  logic         t_0_req;
  logic         t_0_ack;
  logic [W-1:0] i_0_dat;
  logic         i_0_req;
  logic         i_0_ack;
  logic [W-1:0] i_1_dat;
  logic         i_1_req;
  logic         i_1_ack;
  logic [1:0]   state_dbg;

  fork2_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .t_0_dat(t_0_dat), .t_0_req(t_0_req), .t_0_ack(t_0_ack),
    .i_0_dat(i_0_dat), .i_0_req(i_0_req), .i_0_ack(i_0_ack),
    .i_1_dat(i_1_dat), .i_1_req(i_1_req), .i_1_ack(i_1_ack),
    .state_dbg(state_dbg)
  );

  // scoreboard / reference model
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];
  logic [W-1:0] last_word;
  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_del0   = 0;
  int n_del1   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp0_q.delete();
    exp1_q.delete();
    last_word = '0;
  endtask

  // Driver: apply one cycle of inputs, check outputs against the model,
  // clock it, then update the model. Returns 1 if the word was accepted.
  task automatic cycle(input logic r, input logic tq, input logic [W-1:0] d,
                       input logic a0, input logic a1, output logic acc);
    logic take0, take1, exp_ack;
    int left0, left1;
    rst = r; t_0_req = tq; t_0_dat = d; i_0_ack = a0; i_1_ack = a1;
    #1;
    take0 = (exp0_q.size() > 0) && a0;
    take1 = (exp1_q.size() > 0) && a1;
    left0 = exp0_q.size() - (take0 ? 1 : 0);
    left1 = exp1_q.size() - (take1 ? 1 : 0);
    // One word of storage: a new word fits once nothing is owed to either branch.
    exp_ack = (left0 == 0) && (left1 == 0);
    check("t_0_ack", W'(t_0_ack), W'(exp_ack));
    check("i_0_req", W'(i_0_req), W'(exp0_q.size() > 0));
    check("i_1_req", W'(i_1_req), W'(exp1_q.size() > 0));
    check("i_0_dat", i_0_dat, last_word);
    check("i_1_dat", i_1_dat, last_word);
    acc = 1'b0;
    if (!r) begin
      if (take0) begin check("br0_order", i_0_dat, exp0_q[0]); void'(exp0_q.pop_front()); n_del0++; end
      if (take1) begin check("br1_order", i_1_dat, exp1_q[0]); void'(exp1_q.pop_front()); n_del1++; end
      if (exp_ack && tq) begin
        exp0_q.push_back(d); exp1_q.push_back(d); last_word = d; n_acc++; acc = 1'b1;
      end
    end
    @(posedge clk);
    if (r) model_reset();
    #1;
  endtask

  logic acc;
  int   cyc;

  initial begin
    rst = 1'b1; t_0_req = 1'b0; t_0_dat = '0; i_0_ack = 1'b0; i_1_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_i_0_req", W'(i_0_req), '0);
    check("rst_i_1_req", W'(i_1_req), '0);
    check("rst_i_0_dat", i_0_dat, '0);
    check("rst_i_1_dat", i_1_dat, '0);
    check("rst_t_0_ack", W'(t_0_ack), W'(1));
    check("rst_state", W'(state_dbg), '0);

    // single word with both branches taking it at once
    cycle(0, 1, 32'h0000_00A5, 1, 1, acc);
    check("a5_req0", W'(i_0_req), W'(1));
    check("a5_req1", W'(i_1_req), W'(1));
    check("a5_dat0", i_0_dat, 32'hA5);
    check("a5_dat1", i_1_dat, 32'hA5);
    cycle(0, 0, 0, 1, 1, acc);
    check("a5_done0", W'(i_0_req), '0);
    check("a5_done1", W'(i_1_req), '0);

    // branch 0 takes the word first, branch 1 stalls for three cycles
    cycle(0, 1, 32'h1234, 0, 0, acc);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 32'hBEEF, 1, 0, acc);
      check("only1_state", W'(state_dbg), W'(3));
      check("only1_req0", W'(i_0_req), '0);
      check("only1_req1", W'(i_1_req), W'(1));
      check("only1_dat1", i_1_dat, 32'h1234);
      check("only1_noacc", W'(acc), '0);
    end
    cycle(0, 1, 32'hBEEF, 0, 1, acc);
    check("only1_release", W'(acc), W'(1));
    cycle(0, 0, 0, 1, 1, acc);

    // back-to-back stream 1..16 at full rate
    for (int k = 1; k <= 16; k++) begin
      cycle(0, 1, W'(k), 1, 1, acc);
      check("stream_acc", W'(acc), W'(1));
      check("stream_dat", i_0_dat, W'(k));
    end
    cycle(0, 0, 0, 1, 1, acc);

    // ONLY0 freed and reloaded on the same cycle
    cycle(0, 1, 32'h77, 0, 0, acc);
    cycle(0, 0, 0, 0, 1, acc);
    check("only0_state", W'(state_dbg), W'(2));
    cycle(0, 1, 32'h55, 1, 0, acc);
    check("only0_reload", W'(acc), W'(1));
    check("reload_req0", W'(i_0_req), W'(1));
    check("reload_req1", W'(i_1_req), W'(1));
    check("reload_dat", i_1_dat, 32'h55);
    cycle(0, 0, 0, 1, 1, acc);

    // reset while a word is pending on both branches
    cycle(0, 1, 32'hDEAD, 0, 0, acc);
    cycle(1, 1, 32'h9999, 1, 1, acc);
    check("mid_rst_req0", W'(i_0_req), '0);
    check("mid_rst_req1", W'(i_1_req), '0);
    check("mid_rst_dat0", i_0_dat, '0);
    check("mid_rst_dat1", i_1_dat, '0);
    check("mid_rst_ack", W'(t_0_ack), W'(1));
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 1, acc);

    // random traffic: 1000 words with independent branch stalls
    n_acc = 0; n_del0 = 0; n_del1 = 0;
    cyc = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      cycle(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), acc);
      cyc++;
    end
    check("rand_budget", W'(n_acc), W'(1000));
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 1, acc);
    check("rand_drain0", W'(exp0_q.size()), '0);
    check("rand_drain1", W'(exp1_q.size()), '0);
    check("rand_count0", W'(n_del0), W'(n_acc));
    check("rand_count1", W'(n_del1), W'(n_acc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fork2_reg.md
FORK2_REG -- requirements
Module: fork2_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of all streams.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port t_0_dat  input  WIDTH  incoming word.
REQ-005 SHALL have port t_0_req  input  1  incoming word valid.
REQ-006 SHALL have port t_0_ack  output  1  incoming word accepted.
REQ-007 SHALL have port i_0_dat  output  WIDTH  copy of held word, branch 0.
REQ-008 SHALL have port i_0_req  output  1  branch 0 word valid.
REQ-009 SHALL have port i_0_ack  input  1  branch 0 word taken.
REQ-010 SHALL have port i_1_dat  output  WIDTH  copy of held word, branch 1.
REQ-011 SHALL have port i_1_req  output  1  branch 1 word valid.
REQ-012 SHALL have port i_1_ack  input  1  branch 1 word taken.

Function
REQ-013 SHALL treat a transfer on any stream as req=1 and ack=1 in the same cycle; req=1 with ack=0 moves nothing.
REQ-014 SHALL hold one WIDTH-bit data register and a 2-bit state: EMPTY (no word), BOTH (both branches pending), ONLY0 (only branch 0 pending), ONLY1 (only branch 1 pending).
REQ-015 SHALL drive i_0_dat and i_1_dat from the data register, unchanged while the corresponding req is 1.
REQ-016 SHALL drive i_0_req = (state==BOTH or ONLY0) and i_1_req = (state==BOTH or ONLY1), from registered state only, never combinationally from any ack.
REQ-017 SHALL drive t_0_ack = 1 when state==EMPTY, or BOTH with i_0_ack and i_1_ack both 1, or ONLY0 with i_0_ack=1, or ONLY1 with i_1_ack=1; otherwise 0; t_0_ack SHALL NOT depend on t_0_req.
REQ-018 SHALL, on any cycle where the held word is fully delivered (last pending branch acks) or state is EMPTY, load t_0_dat and enter BOTH if t_0_req=1, else enter EMPTY.
REQ-019 SHALL, in BOTH, go to ONLY1 on i_0_ack=1 with i_1_ack=0, go to ONLY0 on i_1_ack=1 with i_0_ack=0, and stay in BOTH when neither acks.
REQ-020 SHALL, in ONLY0, ignore i_1_ack and stay in ONLY0 until i_0_ack=1; symmetrically for ONLY1 and i_0_ack.
REQ-021 SHALL deliver each accepted word exactly once on each branch, in acceptance order, with no duplication or loss.
REQ-022 SHALL have latency of one cycle: a word accepted at edge N is presented on both branches in the cycle after edge N.
REQ-023 SHALL sustain one word per cycle when both branches ack every cycle (back-to-back BOTH->BOTH).
REQ-024 SHALL leave the data register unchanged on every cycle where no input transfer occurs.

Reset
REQ-025 SHALL, while rst=1 at a rising edge, set state to EMPTY and the data register to 0, giving i_0_req=0, i_1_req=0, i_0_dat=0, i_1_dat=0 after that edge.
REQ-026 SHALL hold t_0_ack=1 after reset (EMPTY) but SHALL ignore any input transfer in a cycle where rst=1.
REQ-027 SHALL, on reset asserted mid-operation (BOTH/ONLY0/ONLY1), discard the held word without delivering it to any pending branch.

Verification
REQ-028 SHALL pass: reset, then t_0_dat=0x0000_00A5, t_0_req=1 one cycle, both acks held 1 -> next cycle i_0_req=i_1_req=1, both dat=0xA5; following cycle both req=0.
REQ-029 SHALL pass: word 0x1234 held, i_0_ack=1, i_1_ack=0 for 3 cycles then 1 -> state ONLY1 for 3 cycles, i_0_req=0, i_1_req=1 with dat 0x1234, t_0_ack=0 until i_1_ack=1.
REQ-030 SHALL pass: stream 1,2,3,...,16 with t_0_req and both acks held 1 -> t_0_ack=1 every cycle, each branch receives 1..16 in order on 16 consecutive cycles.
REQ-031 SHALL pass: random independent 50% ack patterns on i_0/i_1 and random t_0_req over 1000 words -> both branch scoreboards equal input sequence, dat stable while req=1 and ack=0.
REQ-032 SHALL pass: word 0xDEAD in BOTH, rst=1 one cycle -> next cycle i_0_req=i_1_req=0, dats=0, t_0_ack=1; 0xDEAD never appears as a transfer afterwards.
REQ-033 SHALL pass: ONLY0 with t_0_req=1 (0x55) and i_0_ack=1 in same cycle -> t_0_ack=1 that cycle, next cycle state BOTH presenting 0x55 on both branches.
